// File: rtl/text_stream_ctrl_if.sv
// Text readout bundle: control pulses, RAM read port and valid/ready byte stream.
// master = controller side (drives RAM address/strobe and the stream), slave = environment side.
interface text_stream_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, ram_q, tx_ready,
    output ram_addr, ram_rden, tx_data, tx_valid, tx_last, busy, done
  );

  modport slave (
    output start, abort, ram_q, tx_ready,
    input  ram_addr, ram_rden, tx_data, tx_valid, tx_last, busy, done
  );
endinterface

// File: rtl/text_stream_ctrl.sv
// Streams RAM bytes 0..END_ADDR on valid/ready; first byte 3 cycles after start, 1 byte/cycle.
// Full backpressure: reads are issued only while buffer occupancy plus in-flight read stays below 2.
module text_stream_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int END_ADDR = 10
) (
  input  logic               clk,
  input  logic               reset,
  text_stream_ctrl_if.master bus
);

  localparam logic [ADDR_W-1:0] END_A = ADDR_W'(END_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [DATA_W-1:0] r_fifo_dat [2];
  logic [1:0]        r_fifo_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_busy;
  logic              r_done;

  logic              w_xfer;
  logic [2:0]        w_occ;
  logic              w_rden;
  logic              w_rd_last;

  assign w_xfer    = (r_count != 2'd0) && bus.tx_ready;
  // Occupancy after this cycle's pop; the in-flight read already owns a slot.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_rden    = (r_state == S_STREAM) && (w_occ < 3'd2);
  assign w_rd_last = (r_addr == END_A);

  always_ff @(posedge clk) begin
    if (reset || bus.abort) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_fifo_dat[0]   <= '0;
      r_fifo_dat[1]   <= '0;
      r_fifo_last     <= 2'b00;
      r_wr_ptr        <= 1'b0;
      r_rd_ptr        <= 1'b0;
      r_count         <= 2'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_rden;
      r_inflight_last <= w_rden && w_rd_last;

      if (r_inflight) begin
        r_fifo_dat[r_wr_ptr]  <= bus.ram_q;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case ({r_inflight, w_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      // Counter parks on END_ADDR after the final read; cleared on the way back to idle.
      if (w_rden && !w_rd_last) begin
        r_addr <= r_addr + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_STREAM;
            r_busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_rden && w_rd_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_xfer && r_fifo_last[r_rd_ptr]) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_addr  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr = r_addr;
  assign bus.ram_rden = w_rden;
  assign bus.tx_valid = (r_count != 2'd0);
  assign bus.tx_data  = r_fifo_dat[r_rd_ptr];
  assign bus.tx_last  = (r_count != 2'd0) && r_fifo_last[r_rd_ptr];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_text_stream_ctrl.sv
// Directed bench for text_stream_ctrl: an 11-byte message instance and a single-byte instance.
`timescale 1ns/1ps
module tb_text_stream_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_stream_ctrl_if bus0 ();
  text_stream_ctrl_if bus1 ();

  text_stream_ctrl #(.ADDR_W(8), .DATA_W(8), .END_ADDR(10)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  text_stream_ctrl #(.ADDR_W(8), .DATA_W(8), .END_ADDR(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // RAM contents: RAM[i] = 8'h41 + i, one-cycle registered read.
  always @(posedge clk) begin
    if (bus0.ram_rden) bus0.ram_q <= 8'h41 + bus0.ram_addr;
    if (bus1.ram_rden) bus1.ram_q <= 8'h41 + bus1.ram_addr;
  end

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [7:0] got_dat [$];
  bit         got_last[$];
  int         got_cyc [$];
  int         done_cnt;
  int         done_cyc;
  bit         prev_stall;
  logic [7:0] prev_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rec();
    got_dat.delete();
    got_last.delete();
    got_cyc.delete();
    done_cnt   = 0;
    done_cyc   = -1;
    prev_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle on instance 0: drive inputs, sample, record transfers/done, advance.
  task automatic do_cycle(input bit rdy, input bit st, input bit ab, input bit rs);
    bus0.tx_ready = rdy;
    bus0.start    = st;
    bus0.abort    = ab;
    reset         = rs;
    #1;
    if (prev_stall) begin
      chk("hold_valid", bus0.tx_valid, 1);
      chk("hold_data", bus0.tx_data, prev_dat);
    end
    if (bus0.tx_valid && rdy) begin
      got_dat.push_back(bus0.tx_data);
      got_last.push_back(bus0.tx_last);
      got_cyc.push_back(cyc);
    end
    if (bus0.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = bus0.tx_valid && !rdy && !rs && !ab;
    prev_dat   = bus0.tx_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_msg(input string tag);
    chk({tag, "_count"}, got_dat.size(), 11);
    for (int k = 0; k < got_dat.size() && k < 11; k++) begin
      chk({tag, "_data"}, got_dat[k], 8'h41 + k);
      chk({tag, "_last"}, got_last[k], (k == 10) ? 1 : 0);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_end"}, bus0.busy, 0);
  endtask

  task automatic run_msg(input string tag);
    clear_rec();
    do_cycle(1, 1, 0, 0);
    repeat (19) do_cycle(1, 0, 0, 0);
    chk_msg(tag);
  endtask

  task automatic chk_idle0(input string tag);
    chk({tag, "_valid"}, bus0.tx_valid, 0);
    chk({tag, "_busy"},  bus0.busy, 0);
    chk({tag, "_rden"},  bus0.ram_rden, 0);
    chk({tag, "_addr"},  bus0.ram_addr, 0);
    chk({tag, "_last"},  bus0.tx_last, 0);
    chk({tag, "_done"},  bus0.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    reset         = 1'b1;
    bus0.start    = 1'b0; bus0.abort = 1'b0; bus0.tx_ready = 1'b0;
    bus1.start    = 1'b0; bus1.abort = 1'b0; bus1.tx_ready = 1'b0;
    clear_rec();
    tick();

    // Reset state
    do_cycle(0, 0, 0, 1);
    do_cycle(0, 0, 0, 1);
    chk_idle0("reset");
    chk("reset_i1_valid", bus1.tx_valid, 0);

    // Test 1: full-rate message with timing
    clear_rec();
    s = cyc;
    do_cycle(1, 1, 0, 0);
    chk("t1_c1_rden", bus0.ram_rden, 1);
    chk("t1_c1_addr", bus0.ram_addr, 0);
    chk("t1_c1_busy", bus0.busy, 1);
    chk("t1_c1_valid", bus0.tx_valid, 0);
    do_cycle(1, 0, 0, 0);
    chk("t1_c2_valid", bus0.tx_valid, 0);
    chk("t1_c2_addr", bus0.ram_addr, 1);
    repeat (20) do_cycle(1, 0, 0, 0);
    chk_msg("t1");
    for (int k = 0; k < got_cyc.size() && k < 11; k++) begin
      chk("t1_xfer_cycle", got_cyc[k], s + 3 + k);
    end
    chk("t1_done_cycle", done_cyc, s + 14);

    // Test 2/3: ready pattern 1,0,0,1 with an ignored mid-message start
    clear_rec();
    do_cycle(1, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      do_cycle(pat[i % 4], (i == 8), 0, 0);
    end
    chk_msg("t2");

    // Test 3: restart after done begins at address 0
    run_msg("t3");

    // Test 4: reset right after the 4th transfer
    clear_rec();
    do_cycle(1, 1, 0, 0);
    for (int i = 0; i < 12 && got_dat.size() < 4; i++) begin
      do_cycle(1, 0, 0, 0);
    end
    chk("t4_four_xfers", got_dat.size(), 4);
    if (got_dat.size() >= 4) chk("t4_fourth_byte", got_dat[3], 8'h44);
    do_cycle(0, 0, 0, 1);
    chk_idle0("t4_after_reset");
    clear_rec();
    repeat (4) do_cycle(1, 0, 0, 0);
    chk("t4_no_stale", got_dat.size(), 0);
    chk("t4_no_done", done_cnt, 0);
    run_msg("t4_restart");

    // Test 5: abort with a byte buffered and a read in flight
    clear_rec();
    do_cycle(0, 1, 0, 0);
    do_cycle(0, 0, 0, 0);
    do_cycle(0, 0, 0, 0);
    chk("t5_pre_valid", bus0.tx_valid, 1);
    chk("t5_pre_data", bus0.tx_data, 8'h41);
    chk("t5_pre_rden", bus0.ram_rden, 0);
    chk("t5_pre_addr", bus0.ram_addr, 2);
    do_cycle(0, 0, 1, 0);
    chk_idle0("t5_after_abort");
    repeat (6) do_cycle(1, 0, 0, 0);
    chk("t5_no_stale", got_dat.size(), 0);
    chk("t5_no_done", done_cnt, 0);
    run_msg("t5_restart");

    // Test 6: single-byte message under initial backpressure
    bus1.start = 1'b1; bus1.tx_ready = 1'b0;
    tick();
    bus1.start = 1'b0;
    #1;
    chk("t6_c1_rden", bus1.ram_rden, 1);
    chk("t6_c1_addr", bus1.ram_addr, 0);
    chk("t6_c1_busy", bus1.busy, 1);
    tick();
    #1;
    chk("t6_c2_valid", bus1.tx_valid, 0);
    chk("t6_c2_rden", bus1.ram_rden, 0);
    chk("t6_c2_busy", bus1.busy, 1);
    tick();
    for (int i = 3; i < 5; i++) begin
      #1;
      chk("t6_stall_valid", bus1.tx_valid, 1);
      chk("t6_stall_data", bus1.tx_data, 8'h41);
      chk("t6_stall_last", bus1.tx_last, 1);
      chk("t6_stall_done", bus1.done, 0);
      tick();
    end
    bus1.tx_ready = 1'b1;
    #1;
    chk("t6_xfer_valid", bus1.tx_valid, 1);
    chk("t6_xfer_data", bus1.tx_data, 8'h41);
    chk("t6_xfer_last", bus1.tx_last, 1);
    tick();
    #1;
    chk("t6_done", bus1.done, 1);
    chk("t6_done_busy", bus1.busy, 0);
    chk("t6_done_valid", bus1.tx_valid, 0);
    tick();
    #1;
    chk("t6_done_once", bus1.done, 0);
    chk("t6_idle_addr", bus1.ram_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
